mem_port_arbiter: RTL and testbench

- Shares the core's single 128-bit memory request/response port between NUM_REQ requesters (L1I, L1D, page-table walker).
- Round-robin grant. At most one memory transaction outstanding.
- Sits between the cache/walker blocks and the external memory interface.
- Routes each response back to its originator and flags protocol faults: response timeout and spurious response.

---
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit memory port between NUM_REQ requesters.
// Keeps at most one transaction outstanding and flags response timeouts and spurious responses.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no transaction outstanding; grants the next requester
// S_ISSUE | one-cycle mem_req_valid pulse carrying the latched request
// S_WAIT  | awaiting mem_rsp_valid; watchdog counts down to timeout
module mem_port_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*64-1:0]        req_addr,
    input  logic [NUM_REQ*4-1:0]         req_opcode,
    input  logic [NUM_REQ*128-1:0]       req_store_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [127:0]                 rsp_load_data,
    output logic                         mem_req_valid,
    output logic [63:0]                  mem_req_addr,
    output logic [3:0]                   mem_req_opcode,
    output logic [127:0]                 mem_req_store_data,
    input  logic                         mem_rsp_valid,
    input  logic [127:0]                 mem_rsp_load_data,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   cur_owner,
    output logic                         timeout,
    output logic                         spurious_rsp
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [OWN_W:0]   SH_ONE  = (OWN_W + 1)'(1);
    localparam logic [OWN_W-1:0] LAST_RST = OWN_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [OWN_W-1:0]   r_last_q, r_last_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [63:0]        addr_q, addr_d;
    logic [3:0]         opc_q, opc_d;
    logic [127:0]       data_q, data_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [127:0]       rsp_data_q, rsp_data_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               timeout_q, timeout_d;
    logic               spur_q, spur_d;

    logic               gnt_found;
    logic [OWN_W-1:0]   gnt_idx;
    logic [OWN_W:0]     shamt;
    logic [NUM_REQ-1:0] req_rot;
    logic [63:0]        addr_sel;
    logic [3:0]         opc_sel;
    logic [127:0]       data_sel;
    int                 gnt_off;
    int                 gnt_sum;

    // Rotate requests so bit 0 is the index just after the last grantee, then take the lowest set bit.
    always_comb begin
        shamt     = {1'b0, r_last_q} + SH_ONE;
        req_rot   = NUM_REQ'({req_valid, req_valid} >> shamt);
        gnt_found = |req_valid;
        gnt_off   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) gnt_off = k;
        end
        gnt_sum = int'(r_last_q) + 1 + gnt_off;
        if (gnt_sum >= NUM_REQ) gnt_sum = gnt_sum - NUM_REQ;
        gnt_idx = OWN_W'(gnt_sum);
    end

    always_comb begin
        addr_sel = '0;
        opc_sel  = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == OWN_W'(i)) begin
                addr_sel = req_addr[64*i +: 64];
                opc_sel  = req_opcode[4*i +: 4];
                data_sel = req_store_data[128*i +: 128];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        r_last_d    = r_last_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        opc_d       = opc_q;
        data_d      = data_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        wdog_d      = wdog_q;
        timeout_d   = timeout_q;
        spur_d      = spur_q;
        case (state_q)
            S_IDLE: begin
                if (mem_rsp_valid) spur_d = 1'b1;
                if (gnt_found) begin
                    state_d  = S_ISSUE;
                    r_last_d = gnt_idx;
                    owner_d  = gnt_idx;
                    addr_d   = addr_sel;
                    opc_d    = opc_sel;
                    data_d   = data_sel;
                    wdog_d   = WD_LOAD;
                end
            end
            S_ISSUE: begin
                if (mem_rsp_valid) spur_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d    = S_IDLE;
                    rsp_data_d = mem_rsp_load_data;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        rsp_valid_d[i] = (owner_q == OWN_W'(i));
                    end
                end else if (wdog_q == '0) begin
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q - WD_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            r_last_q    <= LAST_RST;
            owner_q     <= '0;
            addr_q      <= '0;
            opc_q       <= '0;
            data_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_last_q    <= r_last_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            opc_q       <= opc_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
            spur_q      <= spur_d;
        end
    end

    // Grant is combinational; held off while reset is asserted so no ack leaks out.
    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = reset && (state_q == S_IDLE) && gnt_found && (gnt_idx == OWN_W'(i));
        end
    end

    assign busy               = (state_q != S_IDLE) || (reset && gnt_found);
    assign mem_req_valid      = (state_q == S_ISSUE);
    assign mem_req_addr       = addr_q;
    assign mem_req_opcode     = opc_q;
    assign mem_req_store_data = data_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_load_data      = rsp_data_q;
    assign cur_owner          = owner_q;
    assign timeout            = timeout_q;
    assign spurious_rsp       = spur_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter; round-robin expectations come
// from a small arithmetic model of pending requests and the last grantee.
module tb_mem_port_arbiter;
    localparam int NR = 3;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*64-1:0]  req_addr;
    logic [NR*4-1:0]   req_opcode;
    logic [NR*128-1:0] req_store_data;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     rsp_valid;
    logic [127:0]      rsp_load_data;
    logic              mem_req_valid;
    logic [63:0]       mem_req_addr;
    logic [3:0]        mem_req_opcode;
    logic [127:0]      mem_req_store_data;
    logic              mem_rsp_valid;
    logic [127:0]      mem_rsp_load_data;
    logic              busy;
    logic [1:0]        cur_owner;
    logic              timeout;
    logic              spurious_rsp;

    mem_port_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_opcode(req_opcode), .req_store_data(req_store_data), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_load_data(rsp_load_data), .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr), .mem_req_opcode(mem_req_opcode),
        .mem_req_store_data(mem_req_store_data), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_load_data(mem_rsp_load_data), .busy(busy), .cur_owner(cur_owner),
        .timeout(timeout), .spurious_rsp(spurious_rsp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mem_req_cnt = 0;

    logic [63:0]  addr_t [NR];
    logic [3:0]   opc_t  [NR];
    logic [127:0] data_t [NR];
    logic [NR-1:0] pend;
    int m_last;

    always @(negedge clk) if (mem_req_valid === 1'b1) mem_req_cnt++;

    initial begin
        #500000;
        $display("FAIL sim_time_limit observed=expired expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < NR; i++) begin
            req_addr[64*i +: 64]        = addr_t[i];
            req_opcode[4*i +: 4]        = opc_t[i];
            req_store_data[128*i +: 128] = data_t[i];
        end
    endtask

    task automatic new_req(input int i);
        addr_t[i] = {$urandom, $urandom};
        opc_t[i]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                  : (($urandom_range(0, 1) == 0) ? 4'd4 : 4'd7);
        data_t[i] = {$urandom, $urandom, $urandom, $urandom};
        pend[i]   = 1'b1;
    endtask

    // Round robin: first pending index after the last grantee, wrapping.
    function automatic int pick(input logic [NR-1:0] p, input int last);
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (p[c]) return c;
        end
        return 0;
    endfunction

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic grant_issue(output int g);
        drive(); #1;
        g = pick(pend, m_last);
        chk("req_ack", req_ack, 1 << g);
        chk("busy_grant", busy, 1);
        pend[g] = 1'b0;
        m_last  = g;
        next_cycle(); drive(); #1;
        chk("mem_req_valid", mem_req_valid, 1);
        chk("mem_req_addr", mem_req_addr, addr_t[g]);
        chk("mem_req_opcode", mem_req_opcode, opc_t[g]);
        chk("mem_req_data", mem_req_store_data, data_t[g]);
        chk("cur_owner", cur_owner, g);
        chk("no_ack_issue", req_ack, 0);
    endtask

    task automatic txn(input int lat, input logic [127:0] rdata, input bit rereq, output int g);
        grant_issue(g);
        repeat (lat) begin
            next_cycle(); drive(); #1;
            chk("wait_no_memreq", mem_req_valid, 0);
            chk("wait_busy", busy, 1);
        end
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_load_data = rdata;
        drive(); #1;
        chk("rsp_not_early", rsp_valid, 0);
        next_cycle();
        mem_rsp_valid = 1'b0;
        mem_rsp_load_data = {$urandom, $urandom, $urandom, $urandom};
        if (rereq) new_req(g);
        drive(); #1;
        chk("rsp_valid", rsp_valid, 1 << g);
        chk("rsp_data", rsp_load_data, rdata);
        chk("busy_after_rsp", busy, pend != 0);
    endtask

    initial begin
        int g;
        int base;
        logic [127:0] d;

        reset = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_load_data = '0;
        pend = '0;
        m_last = NR - 1;
        for (int i = 0; i < NR; i++) new_req(i);
        drive(); #1;
        chk("rst_no_ack", req_ack, 0);
        next_cycle(); #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_load_data, 0);
        chk("rst_memreq", mem_req_valid, 0);
        chk("rst_memaddr", mem_req_addr, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_spurious", spurious_rsp, 0);
        chk("rst_owner", cur_owner, 0);

        // All three requesting from reset; first three re-request after their response.
        reset = 1'b1;
        base = mem_req_cnt;
        for (int i = 0; i < 6; i++) begin
            txn($urandom_range(0, 3), {$urandom, $urandom, $urandom, $urandom}, i < 3, g);
            chk("rr_order", g, i % 3);
        end
        chk("memreq_per_grant", mem_req_cnt - base, 6);

        // Single load with memory answering in the first WAIT cycle.
        addr_t[0] = 64'h1000;
        opc_t[0]  = 4'd4;
        data_t[0] = '0;
        pend[0]   = 1'b1;
        d = 128'hAAAAAAAAAAAAAAAA5555555555555555;
        txn(0, d, 1'b0, g);
        chk("load_grant", g, 0);
        next_cycle(); #1;
        chk("rsp_pulse_once", rsp_valid, 0);
        chk("rsp_data_hold", rsp_load_data, d);

        // Store from requester 1.
        addr_t[1] = 64'h2040;
        opc_t[1]  = 4'd7;
        data_t[1] = 128'h0123456789ABCDEF0123456789ABCDEF;
        pend[1]   = 1'b1;
        txn(2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, g);
        chk("store_grant", g, 1);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
            if (pend == 0) new_req($urandom_range(0, NR - 1));
            txn($urandom_range(0, 6), {$urandom, $urandom, $urandom, $urandom}, 1'b0, g);
        end
        while (pend != 0) txn($urandom_range(0, 2), {$urandom, $urandom, $urandom, $urandom}, 1'b0, g);
        chk("no_timeout_yet", timeout, 0);
        chk("no_spurious_yet", spurious_rsp, 0);

        // Spurious response while idle.
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_load_data = {4{32'hDEADBEEF}};
        drive();
        next_cycle();
        mem_rsp_valid = 1'b0;
        #1;
        chk("spurious_set", spurious_rsp, 1);
        chk("spurious_no_rsp", rsp_valid, 0);
        chk("spurious_idle", busy, 0);
        new_req(2);
        txn(1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, g);
        chk("spurious_sticky", spurious_rsp, 1);

        // Timeout: no response for TO WAIT cycles.
        new_req(0);
        grant_issue(g);
        for (int k = 0; k < TO; k++) begin
            next_cycle(); drive(); #1;
            chk("timeout_early", timeout, 0);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle(); drive(); #1;
            chk("timeout_sticky", timeout, 1);
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        mem_rsp_valid = 1'b1;
        mem_rsp_load_data = d;
        next_cycle();
        mem_rsp_valid = 1'b0;
        #1;
        chk("late_rsp_valid", rsp_valid, 1 << g);
        chk("late_rsp_data", rsp_load_data, d);
        chk("timeout_after_rsp", timeout, 1);

        // Reset while waiting abandons the transaction.
        new_req(1);
        grant_issue(g);
        next_cycle(); drive();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        m_last = NR - 1;
        #1;
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_timeout", timeout, 0);
        chk("mrst_spurious", spurious_rsp, 0);
        chk("mrst_owner", cur_owner, 0);
        chk("mrst_memreq", mem_req_valid, 0);
        chk("mrst_memdata", mem_req_store_data, 0);
        chk("mrst_rsp_data", rsp_load_data, 0);
        mem_rsp_valid = 1'b1;
        next_cycle();
        mem_rsp_valid = 1'b0;
        #1;
        chk("mrst_no_rsp", rsp_valid, 0);
        chk("mrst_late_spurious", spurious_rsp, 1);
        for (int i = 0; i < NR; i++) new_req(i);
        txn(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, g);
        chk("mrst_first_grant", g, 0);
        while (pend != 0) txn(1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
